// File: rtl/vip_pkg.sv
// Shared types for the video edge-processing stages: coordinate width,
// default frame geometry, control state and the bounding-box record.
package vip_pkg;
  localparam int COORD_W   = 11;
  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {IDLE, ACTIVE, LATCH} state_e;

  typedef struct packed {
    coord_t x_min;
    coord_t x_max;
    coord_t y_min;
    coord_t y_max;
  } bbox_t;
endpackage

// File: rtl/vip_pixel_coord_counter.sv
// Turns vsync/href/clken into pixel coordinates, a pixel-accept strobe and
// frame-boundary events; reusable by any stage that needs (x, y).
module vip_pixel_coord_counter
  import vip_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en_i,
  input  logic   vsync_i,
  input  logic   href_i,
  input  logic   clken_i,
  output coord_t x_o,
  output coord_t y_o,
  output logic   acc_o,
  output logic   vsync_rise_o,
  output logic   vsync_fall_o
);
  logic   vsync_q, href_q, href_fall;
  coord_t x_q, x_d, y_q, y_d;

  assign vsync_rise_o = vsync_i & ~vsync_q;
  assign vsync_fall_o = ~vsync_i & vsync_q;
  assign href_fall    = ~href_i & href_q;
  assign acc_o        = en_i & vsync_i & href_i & clken_i;
  assign x_o          = x_q;
  assign y_o          = y_q;

  always_comb begin
    x_d = x_q;
    if (href_fall || vsync_rise_o)  x_d = '0;
    else if (acc_o && x_q != '1)    x_d = x_q + 1'b1;
    y_d = y_q;
    if (vsync_rise_o)                          y_d = '0;
    else if (en_i && href_fall && y_q != '1)   y_d = y_q + 1'b1;
  end

  // vsync history resets high so a frame already in progress at reset
  // release never looks like a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b1;
      href_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      vsync_q <= vsync_i;
      href_q  <= href_i;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end
endmodule

// File: rtl/vip_edge_bbox_detector.sv
// Per-frame bounding box and count of edge pixels, latched at frame end
// with a one-cycle frame_done strobe.
module vip_edge_bbox_detector
  import vip_pkg::*;
#(
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int MIN_PIXELS = 64,
  parameter int CNT_W      = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               per_frame_vsync,
  input  logic               per_frame_href,
  input  logic               per_frame_clken,
  input  logic               per_img_bit,
  output logic [COORD_W-1:0] box_x_min,
  output logic [COORD_W-1:0] box_x_max,
  output logic [COORD_W-1:0] box_y_min,
  output logic [COORD_W-1:0] box_y_max,
  output logic [CNT_W-1:0]   edge_cnt,
  output logic               box_valid,
  output logic               frame_done
);
  localparam coord_t           W_LIM = COORD_W'(IMG_W);
  localparam coord_t           H_LIM = COORD_W'(IMG_H);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PIXELS);
  localparam bbox_t BOX_INIT = '{x_min: COORD_W'(IMG_W-1), x_max: '0,
                                 y_min: COORD_W'(IMG_H-1), y_max: '0};

  state_e           state_q;
  bbox_t            acc_q, box_q;
  logic [CNT_W-1:0] cnt_q, edge_cnt_q;
  logic             valid_q, done_q;
  coord_t           x, y;
  logic             acc, vs_rise, vs_fall, edge_px;

  vip_pixel_coord_counter u_coord (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (state_q == ACTIVE),
    .vsync_i      (per_frame_vsync),
    .href_i       (per_frame_href),
    .clken_i      (per_frame_clken),
    .x_o          (x),
    .y_o          (y),
    .acc_o        (acc),
    .vsync_rise_o (vs_rise),
    .vsync_fall_o (vs_fall)
  );

  assign edge_px = acc & per_img_bit & (x < W_LIM) & (y < H_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= BOX_INIT;
      cnt_q      <= '0;
      box_q      <= '0;
      edge_cnt_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (vs_rise) begin
          state_q <= ACTIVE;
          acc_q   <= BOX_INIT;
          cnt_q   <= '0;
        end
        ACTIVE: begin
          if (edge_px) begin
            if (x < acc_q.x_min) acc_q.x_min <= x;
            if (x > acc_q.x_max) acc_q.x_max <= x;
            if (y < acc_q.y_min) acc_q.y_min <= y;
            if (y > acc_q.y_max) acc_q.y_max <= y;
            if (cnt_q != '1)     cnt_q       <= cnt_q + 1'b1;
          end
          if (vs_fall) state_q <= LATCH;
        end
        LATCH: begin
          // Too few pixels: report the count but suppress the box.
          box_q      <= (cnt_q >= MIN_C) ? acc_q : '0;
          valid_q    <= (cnt_q >= MIN_C);
          edge_cnt_q <= cnt_q;
          done_q     <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign box_x_min  = box_q.x_min;
  assign box_x_max  = box_q.x_max;
  assign box_y_min  = box_q.y_min;
  assign box_y_max  = box_q.y_max;
  assign edge_cnt   = edge_cnt_q;
  assign box_valid  = valid_q;
  assign frame_done = done_q;
endmodule
